// File: rtl/leaf_cfg_pkg.sv
// Shared definitions for the leaf configuration master: default widths,
// config packet field offsets, the config port number and the FSM states.
package leaf_cfg_pkg;

    localparam int CFG_PACKET_BITS    = 49;
    localparam int CFG_PAYLOAD_BITS   = 32;
    localparam int CFG_NUM_LEAF_BITS  = 3;
    localparam int CFG_NUM_PORT_BITS  = 4;
    localparam int CFG_NUM_ADDR_BITS  = 7;
    localparam int CFG_CMD_FIFO_DEPTH = 4;

    // Packet layout, MSB first: valid | leaf | port | reg index | 2'b00 | data
    localparam int CFG_DATA_LSB  = 0;
    localparam int CFG_REG_LSB   = CFG_PAYLOAD_BITS + 2;
    localparam int CFG_PORT_LSB  = CFG_REG_LSB + CFG_NUM_ADDR_BITS;
    localparam int CFG_LEAF_LSB  = CFG_PORT_LSB + CFG_NUM_PORT_BITS;
    localparam int CFG_VALID_BIT = CFG_LEAF_LSB + CFG_NUM_LEAF_BITS;

    // Leaf control registers live behind port 0
    localparam int CFG_PORT = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        BCAST = 2'd2
    } cfg_state_e;

endpackage

// File: rtl/cfg_cmd_fifo.sv
// Small synchronous command FIFO with full/empty flags. The head entry is
// visible combinationally on rd_data whenever the FIFO is not empty.
module cfg_cmd_fifo #(
    parameter int WIDTH = 43,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty can be told apart
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Storage array; contents are don't-care while empty so it needs no reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Read and write pointers, flushed by reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/leaf_config_master.sv
// Host-side config master: buffers register-write commands and serializes
// each one into a port-0 config packet on the BFT with ready/valid flow.
// Optional build macro LEAF_CFG_BROADCAST_EN: a command to the all-ones leaf
// is expanded into one packet per leaf 1..max (leaf 0 is the host).
import leaf_cfg_pkg::*;

module leaf_config_master #(
    parameter int PACKET_BITS    = CFG_PACKET_BITS,
    parameter int PAYLOAD_BITS   = CFG_PAYLOAD_BITS,
    parameter int NUM_LEAF_BITS  = CFG_NUM_LEAF_BITS,
    parameter int NUM_PORT_BITS  = CFG_NUM_PORT_BITS,
    parameter int NUM_ADDR_BITS  = CFG_NUM_ADDR_BITS,
    parameter int CMD_FIFO_DEPTH = CFG_CMD_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_cmd_valid,
    output logic                     o_cmd_ready,
    input  logic [NUM_LEAF_BITS-1:0] i_cmd_leaf,
    input  logic [NUM_ADDR_BITS-1:0] i_cmd_reg,
    input  logic [PAYLOAD_BITS-1:0]  i_cmd_data,
    input  logic                     i_cmd_last,
    output logic [PACKET_BITS-1:0]   o_bft_data,
    input  logic                     i_bft_ready,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [15:0]              o_pkt_count
);

    localparam int CMD_BITS = NUM_LEAF_BITS + NUM_ADDR_BITS + PAYLOAD_BITS + 1;
    localparam logic [NUM_LEAF_BITS-1:0] LEAF_MAX = {NUM_LEAF_BITS{1'b1}};

    cfg_state_e state;
    cfg_state_e state_next;

    logic [CMD_BITS-1:0]      fifo_head;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     fifo_push;
    logic                     fifo_pop;

    logic [NUM_LEAF_BITS-1:0] head_leaf;
    logic [NUM_ADDR_BITS-1:0] head_reg;
    logic [PAYLOAD_BITS-1:0]  head_data;
    logic                     head_last;
    logic                     head_is_bcast;

    logic [NUM_LEAF_BITS-1:0] cur_leaf;
    logic [NUM_ADDR_BITS-1:0] cur_reg;
    logic [PAYLOAD_BITS-1:0]  cur_data;
    logic                     cur_last;

    logic                     accept;
    logic                     load;
    logic                     advance_leaf;
    logic                     clear;
    logic                     done_next;

    assign o_cmd_ready = !fifo_full;
    assign fifo_push   = i_cmd_valid && !fifo_full;
    assign o_busy      = !fifo_empty || (state != IDLE);

    cfg_cmd_fifo #(
        .WIDTH (CMD_BITS),
        .DEPTH (CMD_FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .wr_data ({i_cmd_leaf, i_cmd_reg, i_cmd_data, i_cmd_last}),
        .pop     (fifo_pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign head_last = fifo_head[0];
    assign head_data = fifo_head[PAYLOAD_BITS:1];
    assign head_reg  = fifo_head[PAYLOAD_BITS+NUM_ADDR_BITS:PAYLOAD_BITS+1];
    assign head_leaf = fifo_head[CMD_BITS-1 -: NUM_LEAF_BITS];

`ifdef LEAF_CFG_BROADCAST_EN
    assign head_is_bcast = (head_leaf == LEAF_MAX);
`else
    assign head_is_bcast = 1'b0;
`endif

    // Assemble the outgoing packet; everything reads zero while idle
    always_comb begin
        o_bft_data                                   = '0;
        o_bft_data[CFG_VALID_BIT]                    = (state != IDLE);
        o_bft_data[CFG_LEAF_LSB +: NUM_LEAF_BITS]    = cur_leaf;
        o_bft_data[CFG_PORT_LSB +: NUM_PORT_BITS]    = NUM_PORT_BITS'(CFG_PORT);
        o_bft_data[CFG_REG_LSB +: NUM_ADDR_BITS]     = cur_reg;
        o_bft_data[CFG_DATA_LSB +: PAYLOAD_BITS]     = cur_data;
    end

    // Next-state logic: load from the FIFO when idle or after an acceptance,
    // step through leaves while broadcasting, otherwise fall back to idle
    always_comb begin
        state_next   = state;
        fifo_pop     = 1'b0;
        load         = 1'b0;
        advance_leaf = 1'b0;
        clear        = 1'b0;
        accept       = (state != IDLE) && i_bft_ready;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    load       = 1'b1;
                    state_next = head_is_bcast ? BCAST : SEND;
                end
            end
            SEND, BCAST: begin
                if (i_bft_ready) begin
                    if ((state == BCAST) && (cur_leaf != LEAF_MAX)) begin
                        advance_leaf = 1'b1;
                    end else if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        load       = 1'b1;
                        state_next = head_is_bcast ? BCAST : SEND;
                    end else begin
                        clear      = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        done_next = accept && cur_last && !advance_leaf;
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Packet holding register: loaded on pop, stepped during broadcast,
    // cleared when the last packet leaves and nothing is queued
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_leaf <= '0;
            cur_reg  <= '0;
            cur_data <= '0;
            cur_last <= 1'b0;
        end else if (load) begin
            cur_leaf <= head_is_bcast ? NUM_LEAF_BITS'(1) : head_leaf;
            cur_reg  <= head_reg;
            cur_data <= head_data;
            cur_last <= head_last;
        end else if (advance_leaf) begin
            cur_leaf <= cur_leaf + NUM_LEAF_BITS'(1);
        end else if (clear) begin
            cur_leaf <= '0;
            cur_reg  <= '0;
            cur_data <= '0;
            cur_last <= 1'b0;
        end
    end

    // Completion pulse and free-running count of accepted packets
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_done      <= 1'b0;
            o_pkt_count <= '0;
        end else begin
            o_done <= done_next;
            if (accept) begin
                o_pkt_count <= o_pkt_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_leaf_config_master.sv
// Self-checking bench for leaf_config_master: directed scenarios followed by
// random traffic, all compared against a queue-based transaction model.
// Honours LEAF_CFG_BROADCAST_EN the same way the design does.
module tb_leaf_config_master;

`ifdef LEAF_CFG_BROADCAST_EN
    localparam bit BCAST_EN = 1'b1;
`else
    localparam bit BCAST_EN = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic [2:0]  i_cmd_leaf;
    logic [6:0]  i_cmd_reg;
    logic [31:0] i_cmd_data;
    logic        i_cmd_last;
    logic [48:0] o_bft_data;
    logic        i_bft_ready;
    logic        o_busy;
    logic        o_done;
    logic [15:0] o_pkt_count;

    leaf_config_master dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_cmd_valid (i_cmd_valid),
        .o_cmd_ready (o_cmd_ready),
        .i_cmd_leaf  (i_cmd_leaf),
        .i_cmd_reg   (i_cmd_reg),
        .i_cmd_data  (i_cmd_data),
        .i_cmd_last  (i_cmd_last),
        .o_bft_data  (o_bft_data),
        .i_bft_ready (i_bft_ready),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_pkt_count (o_pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  leaf;
        logic [6:0]  rg;
        logic [31:0] data;
        logic        last;
    } cmd_t;

    // Reference model: commands waiting, the command on the wire, and the
    // leaf it is currently addressed to
    cmd_t        mq[$];
    cmd_t        m_cur;
    bit          m_cur_valid;
    bit          m_bcast;
    logic [2:0]  m_leaf;
    bit          m_done;
    logic [15:0] m_count;
    bit          m_wrapped;

    int vectors;
    int miscompares;

    task automatic modelReset();
        mq.delete();
        m_cur_valid = 1'b0;
        m_bcast     = 1'b0;
        m_leaf      = '0;
        m_done      = 1'b0;
        m_count     = '0;
    endtask

    // Advance the model by one clock edge given the inputs seen at that edge
    task automatic modelEdge(input bit v, input cmd_t c, input bit rdy);
        bit accept;
        bit final_pkt;
        int pre_size;
        accept    = m_cur_valid && rdy;
        final_pkt = !m_bcast || (m_leaf == 3'd7);
        pre_size  = mq.size();
        m_done    = accept && m_cur.last && final_pkt;
        if (accept) begin
            if (m_count == 16'hFFFF) m_wrapped = 1'b1;
            m_count = m_count + 16'd1;
        end
        if (accept && !final_pkt) begin
            m_leaf = m_leaf + 3'd1;
        end else if ((!m_cur_valid || accept) && pre_size > 0) begin
            m_cur       = mq.pop_front();
            m_cur_valid = 1'b1;
            m_bcast     = BCAST_EN && (m_cur.leaf == 3'd7);
            m_leaf      = m_bcast ? 3'd1 : m_cur.leaf;
        end else if (accept) begin
            m_cur_valid = 1'b0;
        end
        if (v && pre_size < 4) mq.push_back(c);
    endtask

    task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model's current view
    task automatic checkOutput();
        logic [48:0] exp_pkt;
        exp_pkt = {1'b1, m_leaf, 4'd0, m_cur.rg, 2'b00, m_cur.data};
        checkValue("cmd_ready", 64'(o_cmd_ready), 64'(mq.size() < 4));
        checkValue("busy", 64'(o_busy), 64'(mq.size() > 0 || m_cur_valid));
        checkValue("done", 64'(o_done), 64'(m_done));
        checkValue("pkt_count", 64'(o_pkt_count), 64'(m_count));
        if (m_cur_valid) checkValue("bft_data", 64'(o_bft_data), 64'(exp_pkt));
        else             checkValue("bft_valid", 64'(o_bft_data[48]), 64'd0);
    endtask

    // Drive one cycle of inputs, advance the model at the edge, check after
    task automatic applyStimulus(input bit v, input logic [2:0] lf, input logic [6:0] rg,
                                 input logic [31:0] d, input bit lst, input bit rdy);
        cmd_t c;
        c.leaf = lf; c.rg = rg; c.data = d; c.last = lst;
        i_cmd_valid = v;
        i_cmd_leaf  = lf;
        i_cmd_reg   = rg;
        i_cmd_data  = d;
        i_cmd_last  = lst;
        i_bft_ready = rdy;
        @(posedge clk);
        modelEdge(v, c, rdy);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic idleCycles(input int n, input bit rdy);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 3'd0, 7'd0, 32'd0, 1'b0, rdy);
    endtask

    initial begin
        logic [48:0] first_pkt;
        int          budget;
        vectors     = 0;
        miscompares = 0;
        m_wrapped   = 1'b0;
        modelReset();
        reset_n     = 1'b0;
        i_cmd_valid = 1'b0;
        i_cmd_leaf  = '0;
        i_cmd_reg   = '0;
        i_cmd_data  = '0;
        i_cmd_last  = 1'b0;
        i_bft_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput();
        checkValue("reset_bft_data", 64'(o_bft_data), 64'd0);
        reset_n = 1'b1;

        $display("[TB] single write");
        first_pkt = {1'b1, 3'd3, 4'd0, 7'h05, 2'b00, 32'hDEADBEEF};
        applyStimulus(1'b1, 3'd3, 7'h05, 32'hDEADBEEF, 1'b1, 1'b1);
        checkValue("single_not_yet", 64'(o_bft_data[48]), 64'd0);
        applyStimulus(1'b0, 3'd0, 7'd0, 32'd0, 1'b0, 1'b1);
        checkValue("single_pkt", 64'(o_bft_data), 64'(first_pkt));
        applyStimulus(1'b0, 3'd0, 7'd0, 32'd0, 1'b0, 1'b1);
        checkValue("single_done", 64'(o_done), 64'd1);
        checkValue("single_count", 64'(o_pkt_count), 64'd1);
        idleCycles(2, 1'b1);

        $display("[TB] backpressure");
        applyStimulus(1'b1, 3'd2, 7'h11, 32'h12345678, 1'b1, 1'b0);
        idleCycles(6, 1'b0);
        idleCycles(3, 1'b1);
        checkValue("bp_count", 64'(o_pkt_count), 64'd2);

        $display("[TB] fill fifo");
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b1, 3'(i + 1), 7'(i + 'h20), 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
        checkValue("fill_ready_low", 64'(o_cmd_ready), 64'd0);
        idleCycles(7, 1'b1);

        $display("[TB] burst of three");
        applyStimulus(1'b1, 3'd1, 7'h01, 32'h1111_1111, 1'b0, 1'b1);
        applyStimulus(1'b1, 3'd4, 7'h02, 32'h2222_2222, 1'b0, 1'b1);
        applyStimulus(1'b1, 3'd5, 7'h03, 32'h3333_3333, 1'b1, 1'b1);
        idleCycles(5, 1'b1);

        $display("[TB] all-ones leaf");
        applyStimulus(1'b1, 3'd7, 7'h7F, 32'hCAFE_F00D, 1'b1, 1'b0);
        idleCycles(2, 1'b0);
        for (int i = 0; i < 10; i++)
            applyStimulus(1'b0, 3'd0, 7'd0, 32'd0, 1'b0, (i % 3) != 1);

        $display("[TB] reset mid-send");
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 3'd6, 7'(i), 32'hBEEF_0000 + 32'(i), 1'b1, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        modelReset();
        checkOutput();
        checkValue("rst_bft_zero", 64'(o_bft_data), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        idleCycles(5, 1'b1);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++)
            applyStimulus(($urandom_range(0, 99) < 60), 3'($urandom_range(0, 7)),
                          7'($urandom), 32'($urandom), $urandom_range(0, 1) == 1,
                          ($urandom_range(0, 99) < 70));
        idleCycles(30, 1'b1);

        $display("[TB] count wrap");
        budget = 0;
        while (!m_wrapped && budget < 70000) begin
            applyStimulus(1'b1, 3'($urandom_range(0, 6)), 7'($urandom), 32'($urandom), 1'b0, 1'b1);
            budget++;
        end
        checkValue("wrap_reached", 64'(m_wrapped), 64'd1);
        idleCycles(6, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
